// File: rtl/risc15_pkg.sv
// Shared types for the RISC15 boot path: loader states and data widths.
package risc15_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        S_ADDR_HI = 4'd0,
        S_ADDR_LO = 4'd1,
        S_CNT_HI  = 4'd2,
        S_CNT_LO  = 4'd3,
        S_DATA_HI = 4'd4,
        S_DATA_LO = 4'd5,
        S_CHECK   = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

endpackage

// File: rtl/boot_timeout.sv
// Idle-cycle counter: expired fires on the idle cycle that completes TIMEOUT
// consecutive idle cycles, unless a byte clears it on that same cycle.
module boot_timeout #(
    parameter int TIMEOUT = 1024,
    parameter int TMO_W   = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && !clr && (count == LAST);

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: assembles 16-bit words into memory, verifies an
// XOR checksum, then releases the RISC15 core via cpu_run.
module boot_loader
    import risc15_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1024,
    parameter int TMO_W   = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic                cpu_run,
    output logic                load_error,
    output logic [WORD_W-1:0]   words_loaded
);

    state_t              state;
    logic [BYTE_W-1:0]   hdr_hi;
    logic [BYTE_W-1:0]   data_hi;
    logic [BYTE_W-1:0]   csum;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   remaining;
    logic                accept;
    logic                tmo_en;
    logic                expired;

    assign accept = in_valid && in_ready;

    // The line may idle forever before the first header byte arrives.
    assign tmo_en = (state != S_ADDR_HI) && (state != S_DONE)
                 && (state != S_ERROR);

    boot_timeout #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (tmo_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_ADDR_HI;
            in_ready     <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            cpu_run      <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            hdr_hi       <= '0;
            data_hi      <= '0;
            csum         <= '0;
            addr         <= '0;
            remaining    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                unique case (state)
                    S_ADDR_HI: begin
                        hdr_hi <= in_data;
                        state  <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        addr  <= ADDR_W'({hdr_hi, in_data});
                        state <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        hdr_hi <= in_data;
                        state  <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        remaining <= {hdr_hi, in_data};
                        if ({hdr_hi, in_data} == '0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        data_hi <= in_data;
                        csum    <= csum ^ in_data;
                        state   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= {data_hi, in_data};
                        mem_addr     <= addr;
                        addr         <= addr + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                        remaining    <= remaining - 1'b1;
                        csum         <= csum ^ in_data;
                        if (remaining == WORD_W'(1)) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_CHECK: begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state   <= S_DONE;
                            cpu_run <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end else if (expired) begin
                state      <= S_ERROR;
                load_error <= 1'b1;
                in_ready   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader.
module tb_boot_loader;

    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_run;
    logic        load_error;
    logic [15:0] words_loaded;

    int checks;
    int failures;
    int nw;
    int consec;
    logic prev_we;
    logic [15:0] wa [0:15];
    logic [15:0] wd [0:15];

    boot_loader #(
        .ADDR_W  (16),
        .TIMEOUT (TIMEOUT),
        .TMO_W   (11)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .cpu_run      (cpu_run),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: log every write strobe seen at a clock edge.
    always @(posedge clk) begin
        if (mem_we && prev_we) consec++;
        prev_we = mem_we;
        if (mem_we && nw < 16) begin
            wa[nw] = mem_addr;
            wd[nw] = mem_wdata;
            nw++;
        end else if (mem_we) begin
            nw++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        nw    = 0;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_throttled(input logic [7:0] b);
        int tries;
        logic v;
        tries = 0;
        do begin
            v = (tries >= 32) ? 1'b1 : 1'($urandom_range(0, 1));
            in_data  = b;
            in_valid = v;
            @(posedge clk);
            #1;
            tries++;
        end while (!v);
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_nw"}, nw, 2);
        check({tag, "_a0"}, wa[0], 16'h0010);
        check({tag, "_d0"}, wd[0], 16'h1234);
        check({tag, "_a1"}, wa[1], 16'h0011);
        check({tag, "_d1"}, wd[1], 16'hABCD);
        check({tag, "_words"}, words_loaded, 2);
        check({tag, "_run"}, cpu_run, 1);
        check({tag, "_err"}, load_error, 0);
    endtask

    logic [7:0] pkt [0:8];

    initial begin
        checks   = 0;
        failures = 0;
        nw       = 0;
        consec   = 0;
        prev_we  = 1'b0;
        pkt = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};

        do_reset();
        check("rst_ready", in_ready, 1);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_run", cpu_run, 0);
        check("rst_err", load_error, 0);
        check("rst_words", words_loaded, 0);

        // Nominal back-to-back load
        for (int i = 0; i < 8; i++) send(pkt[i]);
        check("nom_we_pulse", mem_we, 1);
        check("nom_we_data", mem_wdata, 16'hABCD);
        check("nom_run_early", cpu_run, 0);
        send(8'h40);
        in_valid = 1'b0;
        check_nominal("nom");
        check("nom_ready", in_ready, 0);
        idle(3);
        check("nom_hold_run", cpu_run, 1);
        check("nom_hold_nw", nw, 2);

        // Bad checksum
        do_reset();
        for (int i = 0; i < 8; i++) send(pkt[i]);
        send(8'h41);
        in_valid = 1'b0;
        check("bad_err", load_error, 1);
        check("bad_run", cpu_run, 0);
        check("bad_ready", in_ready, 0);
        check("bad_nw", nw, 2);
        check("bad_words", words_loaded, 2);
        idle(4);
        check("bad_hold_err", load_error, 1);
        check("bad_hold_nw", nw, 2);

        // Zero-length packet
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h00);
        in_valid = 1'b0;
        check("zero_run", cpu_run, 1);
        check("zero_nw", nw, 0);
        check("zero_err", load_error, 0);

        // Address wrap
        do_reset();
        send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
        send(8'h00); send(8'h01); send(8'h00); send(8'h02);
        send(8'h03);
        in_valid = 1'b0;
        check("wrap_nw", nw, 2);
        check("wrap_a0", wa[0], 16'hFFFF);
        check("wrap_d0", wd[0], 16'h0001);
        check("wrap_a1", wa[1], 16'h0000);
        check("wrap_d1", wd[1], 16'h0002);
        check("wrap_run", cpu_run, 1);

        // Timeout after a partial packet
        do_reset();
        send(8'h00); send(8'h10); send(8'h00); send(8'h01); send(8'h12);
        idle(TIMEOUT - 1);
        check("tmo_early", load_error, 0);
        check("tmo_early_ready", in_ready, 1);
        idle(1);
        check("tmo_err", load_error, 1);
        check("tmo_ready", in_ready, 0);
        check("tmo_run", cpu_run, 0);

        // Long idle before the first byte is legal
        do_reset();
        idle(5000);
        check("preidle_err", load_error, 0);
        check("preidle_ready", in_ready, 1);
        for (int i = 0; i < 9; i++) send(pkt[i]);
        in_valid = 1'b0;
        check_nominal("preidle");

        // Throttled stream
        do_reset();
        for (int i = 0; i < 9; i++) send_throttled(pkt[i]);
        in_valid = 1'b0;
        check_nominal("thr");

        // Reset in S_DATA_LO with a byte presented on the same edge
        do_reset();
        send(8'h00); send(8'h20); send(8'h00); send(8'h02); send(8'h11);
        in_data  = 8'h22;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mid_we", mem_we, 0);
        check("mid_ready", in_ready, 1);
        check("mid_addr", mem_addr, 0);
        check("mid_wdata", mem_wdata, 0);
        check("mid_words", words_loaded, 0);
        check("mid_run", cpu_run, 0);
        check("mid_err", load_error, 0);
        idle(2);
        check("mid_nw", nw, 0);
        nw = 0;
        for (int i = 0; i < 9; i++) send(pkt[i]);
        in_valid = 1'b0;
        check_nominal("mid_reload");

        check("we_consecutive", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
